f_fetch_ctrl: RTL and testbench
===============================

// Module: f_fetch_ctrl
// PURPOSE
//  Fetch-stage sequencer: owns the F-stage PC register and issues requests on the instruction-memory bus.
//  Holds the fetched word for D while D stalls and applies exception/eret redirects.
//  Takes the next PC from the D-stage NPC logic and redirect commands from CP0.
//  Sits between the hazard unit, CP0, the D-stage NPC logic and the instruction bus.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC loaded on reset
//  EXC_VECTOR  32'h0000_4180  exception handler entry
//  TEXT_LO     32'h0000_3000  lowest legal fetch address (range check only)
//  TEXT_HI     32'h0000_6ffc  highest legal fetch address (range check only)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high
//  d_stall      in   1   D cannot accept the held instruction this cycle
//  npc_in       in   32  next PC from the D-stage NPC logic; sampled only on hand-off
//  exc_req      in   1   exception taken: redirect to EXC_VECTOR
//  eret_req     in   1   eret taken: redirect to epc
//  epc          in   32  CP0 EPC
//  imem_req     out  1   bus request
//  imem_addr    out  32  bus address; stable while imem_req && !imem_gnt (except on redirect)
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   read data valid; exactly one per granted request, >=1 cycle after gnt
//  imem_rdata   in   32  instruction word
//  f_pc         out  32  PC of the current or held fetch
//  f_instr      out  32  held instruction; 32'h0 when f_adel=1
//  f_valid      out  1   f_instr/f_pc are valid for D
//  f_adel       out  1   fetch address error (ExcCode AdEL), qualified by f_valid
// BEHAVIOUR
//  States:
//   IDLE  reset only
//   REQ   imem_req=1, imem_addr=f_pc
//   WAIT  awaiting rvalid
//   HOLD  f_valid=1
//   DROP  discard one outstanding rvalid
//  Reset: state=IDLE, f_pc=RESET_PC, f_instr=0, f_valid=0, f_adel=0, imem_req=0.
//   Reset mid-transaction discards any outstanding rvalid; the bus is reset with the core.
//  Transitions:
//   IDLE->REQ next cycle.
//   REQ: gnt -> WAIT.
//   WAIT: rvalid -> HOLD; latch f_instr=rdata, f_valid=1.
//   HOLD: !d_stall -> f_pc<=npc_in, f_valid<=0, REQ.
//  Redirects:
//   Priority exc_req > eret_req; either overrides d_stall and npc_in.
//   Target = EXC_VECTOR or epc. f_pc<=target, f_valid<=0 next cycle.
//   From WAIT, or REQ with gnt in the same cycle -> DROP (pending rvalid discarded).
//   From DROP -> stay in DROP. DROP on rvalid -> REQ.
//   From IDLE/REQ(no gnt)/HOLD -> REQ with the new address next cycle.
//  Misaligned fetch: f_pc[1:0]!=0 in REQ -> no bus request; go to HOLD with f_valid=1, f_adel=1, f_instr=0.
//  Minimum latency, REQ to hand-off: gnt same cycle + rvalid next cycle -> f_valid 2 cycles after REQ entry.
//  f_pc is a plain 32-bit register; npc_in is used verbatim (no wrap handling).
// CONFIGURATION
//  F_FETCH_RANGE_CHK_EN defined:
//   f_pc outside [TEXT_LO,TEXT_HI] is treated like a misaligned fetch.
//   No request; f_adel=1, f_instr=0.
//  F_FETCH_RANGE_CHK_EN undefined:
//   Only alignment is checked; TEXT_LO/TEXT_HI are unused.
// STRUCTURE
//  def.v gains:
//   `FSTATE_IDLE/REQ/WAIT/HOLD/DROP (3-bit encodings)
//   `EXC_VECTOR_DEF, `RESET_PC_DEF, `EXC_ADEL.
//  One sub-module, f_redirect_sel (combinational):
//   exc/eret priority, target select, fetch-address legality (incl. range-check macro).
//  The FSM and registers live in f_fetch_ctrl.
// TESTING
//  1 Reset, then gnt and rvalid each 1 cycle after request.
//    -> imem_addr=0x3000; f_valid=1, f_instr=rdata, f_pc=0x3000.
//  2 d_stall=1 for 3 cycles in HOLD, npc_in=0x3004.
//    -> f_valid stays 1, f_instr unchanged, imem_req=0.
//    Stall drops -> next request addr 0x3004.
//  3 exc_req while in WAIT, then rvalid 2 cycles later.
//    -> that rdata is discarded, f_valid=0; next imem_addr=0x4180.
//  4 exc_req and eret_req together with epc=0x3010.
//    -> target 0x4180; eret ignored.
//  5 eret_req with epc=0x3002.
//    -> no imem_req; f_valid=1, f_adel=1, f_instr=0, f_pc=0x3002.
//  6 With F_FETCH_RANGE_CHK_EN, npc_in=0x7000.
//    -> f_adel=1, no request. Without the macro -> request to 0x7000.

Source files
------------

// File: rtl/f_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
// Fetch-address legality depends on F_FETCH_RANGE_CHK_EN (range check on top of alignment).
package f_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        FSTATE_IDLE = 3'd0,
        FSTATE_REQ  = 3'd1,
        FSTATE_WAIT = 3'd2,
        FSTATE_HOLD = 3'd3,
        FSTATE_DROP = 3'd4
    } fstate_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO        = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI        = 32'h0000_6ffc;
    localparam logic [4:0]  EXC_ADEL       = 5'd4;

    function automatic logic fetch_addr_ok(input logic [31:0] addr);
`ifdef F_FETCH_RANGE_CHK_EN
        return ((addr & 32'h3) == 32'h0) && (addr >= TEXT_LO) && (addr <= TEXT_HI);
`else
        return (addr & 32'h3) == 32'h0;
`endif
    endfunction

endpackage

// File: rtl/f_fetch_ctrl_if.sv
// Instruction-memory bus between the fetch sequencer (master) and memory (slave).
interface f_fetch_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/f_fetch_ctrl_redirect_sel.sv
// Redirect priority (exception over eret), target select and fetch-address legality.
// Legality honours F_FETCH_RANGE_CHK_EN through the package helper.
module f_fetch_ctrl_redirect_sel
    import f_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        exc_req_i,
    input  logic        eret_req_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] npc_i,
    input  logic [31:0] cur_pc_i,
    output logic        redir_o,
    output logic [31:0] target_o,
    output logic        target_ok_o,
    output logic        npc_ok_o,
    output logic        cur_ok_o
);

    always_comb begin
        redir_o     = exc_req_i | eret_req_i;
        target_o    = exc_req_i ? EXC_VECTOR : epc_i;
        target_ok_o = fetch_addr_ok(target_o);
        npc_ok_o    = fetch_addr_ok(npc_i);
        cur_ok_o    = fetch_addr_ok(cur_pc_i);
    end

endmodule

// File: rtl/f_fetch_ctrl.sv
// Fetch-stage sequencer: owns the F-stage PC, drives the instruction bus, holds the word for D.
// Optional range check on fetch addresses is enabled by defining F_FETCH_RANGE_CHK_EN.
module f_fetch_ctrl
    import f_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_stall_i,
    input  logic [31:0]           npc_in_i,
    input  logic                  exc_req_i,
    input  logic                  eret_req_i,
    input  logic [31:0]           epc_i,
    f_fetch_ctrl_if.master        imem,
    output logic [31:0]           f_pc_o,
    output logic [31:0]           f_instr_o,
    output logic                  f_valid_o,
    output logic                  f_adel_o
);

    fstate_e     state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        adel_q;
    logic        req_q;

    logic        redir;
    logic [31:0] target;
    logic        target_ok;
    logic        npc_ok;
    logic        cur_ok;

    f_fetch_ctrl_redirect_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_sel (
        .exc_req_i   (exc_req_i),
        .eret_req_i  (eret_req_i),
        .epc_i       (epc_i),
        .npc_i       (npc_in_i),
        .cur_pc_i    (pc_q),
        .redir_o     (redir),
        .target_o    (target),
        .target_ok_o (target_ok),
        .npc_ok_o    (npc_ok),
        .cur_ok_o    (cur_ok)
    );

    // req_q is computed together with the PC it will present, so a legal
    // address is on the bus in the very first REQ cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FSTATE_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            unique case (state_q)
                FSTATE_IDLE: begin
                    state_q <= FSTATE_REQ;
                    if (redir) begin
                        pc_q  <= target;
                        req_q <= target_ok;
                    end else begin
                        req_q <= cur_ok;
                    end
                end
                FSTATE_REQ: begin
                    if (redir) begin
                        pc_q <= target;
                        if (req_q && imem.imem_gnt) begin
                            state_q <= FSTATE_DROP;
                            req_q   <= 1'b0;
                        end else begin
                            req_q <= target_ok;
                        end
                    end else if (!cur_ok) begin
                        state_q <= FSTATE_HOLD;
                        valid_q <= 1'b1;
                        adel_q  <= 1'b1;
                        instr_q <= 32'h0;
                        req_q   <= 1'b0;
                    end else if (imem.imem_gnt) begin
                        state_q <= FSTATE_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                FSTATE_WAIT: begin
                    if (redir) begin
                        pc_q <= target;
                        // Response landing with the redirect is the one to discard.
                        if (imem.imem_rvalid) begin
                            state_q <= FSTATE_REQ;
                            req_q   <= target_ok;
                        end else begin
                            state_q <= FSTATE_DROP;
                        end
                    end else if (imem.imem_rvalid) begin
                        state_q <= FSTATE_HOLD;
                        instr_q <= imem.imem_rdata;
                        valid_q <= 1'b1;
                        adel_q  <= 1'b0;
                    end
                end
                FSTATE_HOLD: begin
                    if (redir) begin
                        state_q <= FSTATE_REQ;
                        pc_q    <= target;
                        valid_q <= 1'b0;
                        adel_q  <= 1'b0;
                        req_q   <= target_ok;
                    end else if (!d_stall_i) begin
                        state_q <= FSTATE_REQ;
                        pc_q    <= npc_in_i;
                        valid_q <= 1'b0;
                        adel_q  <= 1'b0;
                        req_q   <= npc_ok;
                    end
                end
                FSTATE_DROP: begin
                    if (redir) begin
                        pc_q <= target;
                    end
                    if (imem.imem_rvalid) begin
                        state_q <= FSTATE_REQ;
                        req_q   <= redir ? target_ok : cur_ok;
                    end
                end
                default: begin
                    state_q <= FSTATE_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    adel_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign f_pc_o         = pc_q;
    assign f_instr_o      = instr_q;
    assign f_valid_o      = valid_q;
    assign f_adel_o       = adel_q;

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Directed plus randomized checks of f_fetch_ctrl against a transaction-level fetch model.
module tb_f_fetch_ctrl;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_stall;
    logic [31:0] npc_in;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_valid;
    logic        f_adel;

    int checks = 0;
    int errors = 0;

    f_fetch_ctrl_if bus ();

    f_fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_stall_i  (d_stall),
        .npc_in_i   (npc_in),
        .exc_req_i  (exc_req),
        .eret_req_i (eret_req),
        .epc_i      (epc),
        .imem       (bus.master),
        .f_pc_o     (f_pc),
        .f_instr_o  (f_instr),
        .f_valid_o  (f_valid),
        .f_adel_o   (f_adel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model rule: a fetch address is legal iff word aligned (and in text range when enabled).
    function automatic logic legal(input logic [31:0] a);
`ifdef F_FETCH_RANGE_CHK_EN
        return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6ffc);
`else
        return a % 4 == 0;
`endif
    endfunction

    task automatic wait_req();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'b0, bus.imem_req}, 32'd1);
    endtask

    task automatic check_hold(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic adel);
        chk({tag, "_valid"}, {31'b0, f_valid}, 32'd1);
        chk({tag, "_pc"}, f_pc, pc);
        chk({tag, "_instr"}, f_instr, instr);
        chk({tag, "_adel"}, {31'b0, f_adel}, {31'b0, adel});
        chk({tag, "_noreq"}, {31'b0, bus.imem_req}, 32'd0);
    endtask

    // One complete fetch: request at a, grant after gd cycles, data rd cycles after grant.
    task automatic fetch(input logic [31:0] a, input int gd, input int rd, input logic [31:0] data);
        wait_req();
        chk("addr", bus.imem_addr, a);
        repeat (gd) begin
            tick();
            chk("req_hold", {31'b0, bus.imem_req}, 32'd1);
            chk("addr_stable", bus.imem_addr, a);
        end
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        chk("req_drop", {31'b0, bus.imem_req}, 32'd0);
        repeat (rd - 1) begin
            tick();
            chk("wait_novalid", {31'b0, f_valid}, 32'd0);
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        tick();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        check_hold("hand", a, data, 1'b0);
    endtask

    // Granted fetch flushed by an exception while waiting; its late data must be dropped.
    task automatic flush(input logic [31:0] a, input int xd, input int rd);
        wait_req();
        chk("fl_addr", bus.imem_addr, a);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        repeat (xd) tick();
        exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        chk("fl_valid", {31'b0, f_valid}, 32'd0);
        chk("fl_pc", f_pc, EXC_VEC);
        chk("fl_noreq", {31'b0, bus.imem_req}, 32'd0);
        repeat (rd - 1) tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hdead_beef;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("fl_discard", {31'b0, f_valid}, 32'd0);
        chk("fl_req", {31'b0, bus.imem_req}, 32'd1);
        chk("fl_newaddr", bus.imem_addr, EXC_VEC);
    endtask

    // Hand-off to an illegal address: one cycle without a request, then an AdEL hold.
    task automatic bad_fetch(input logic [31:0] a);
        tick();
        chk("bad_noreq", {31'b0, bus.imem_req}, 32'd0);
        tick();
        check_hold("bad", a, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] d0;
        logic [31:0] npc;
        reset = 1'b1;
        d_stall = 1'b0;
        npc_in = 32'h0;
        exc_req = 1'b0;
        eret_req = 1'b0;
        epc = 32'h0;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        repeat (2) tick();
        chk("rst_pc", f_pc, RST_PC);
        chk("rst_valid", {31'b0, f_valid}, 32'd0);
        chk("rst_instr", f_instr, 32'h0);
        chk("rst_adel", {31'b0, f_adel}, 32'd0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        reset = 1'b0;

        // 1: first fetch, gnt and rvalid each one cycle late
        d_stall = 1'b1;
        fetch(32'h3000, 1, 1, 32'h2408_0001);

        // 2: stall three cycles in HOLD, then hand off to 0x3004
        npc_in = 32'h3004;
        repeat (3) begin
            tick();
            check_hold("stall", 32'h3000, 32'h2408_0001, 1'b0);
        end
        d_stall = 1'b0;
        tick();
        d_stall = 1'b1;
        fetch(32'h3004, 0, 1, 32'h2409_0002);

        // 3: exception in WAIT, rvalid two cycles later is discarded
        npc_in = 32'h3008;
        d_stall = 1'b0;
        tick();
        d_stall = 1'b1;
        flush(32'h3008, 0, 1);
        fetch(EXC_VEC, 0, 1, 32'h4000_6800);

        // 4: exception and eret together: exception wins
        exc_req = 1'b1;
        eret_req = 1'b1;
        epc = 32'h3010;
        tick();
        exc_req = 1'b0;
        eret_req = 1'b0;
        chk("prio_pc", f_pc, EXC_VEC);
        chk("prio_novalid", {31'b0, f_valid}, 32'd0);
        fetch(EXC_VEC, 2, 2, 32'h0000_000c);

        // 5: eret to a misaligned epc
        eret_req = 1'b1;
        epc = 32'h3002;
        tick();
        eret_req = 1'b0;
        chk("mis_noreq", {31'b0, bus.imem_req}, 32'd0);
        tick();
        check_hold("mis", 32'h3002, 32'h0, 1'b1);

        // 6: hand-off to 0x7000 (outside text)
        npc_in = 32'h7000;
        d_stall = 1'b0;
        tick();
        d_stall = 1'b1;
`ifdef F_FETCH_RANGE_CHK_EN
        chk("rng_noreq", {31'b0, bus.imem_req}, 32'd0);
        tick();
        check_hold("rng", 32'h7000, 32'h0, 1'b1);
`else
        fetch(32'h7000, 0, 1, 32'h1234_5678);
`endif

        // 7: eret while a request is still ungranted moves the address
        npc_in = 32'h3020;
        d_stall = 1'b0;
        tick();
        d_stall = 1'b1;
        wait_req();
        chk("rq_addr", bus.imem_addr, 32'h3020);
        eret_req = 1'b1;
        epc = 32'h3100;
        tick();
        eret_req = 1'b0;
        fetch(32'h3100, 1, 1, 32'hcafe_0001);

        // Randomized hand-offs, stalls and flushes against the model
        for (int it = 0; it < 40; it++) begin
            d0 = f_instr;
            npc = f_pc;
            repeat ($urandom_range(0, 2)) begin
                tick();
                check_hold("rstall", npc, d0, f_adel);
            end
            case ($urandom_range(0, 9))
                0:       npc = 32'h3000 + ($urandom_range(0, 4095) * 4) + $urandom_range(1, 3);
                1:       npc = 32'h7000 + ($urandom_range(0, 255) * 4);
                default: npc = 32'h3000 + ($urandom_range(0, 4095) * 4);
            endcase
            npc_in = npc;
            d_stall = 1'b0;
            tick();
            d_stall = 1'b1;
            if (!legal(npc)) begin
                bad_fetch(npc);
            end else if ($urandom_range(0, 4) == 0) begin
                flush(npc, $urandom_range(0, 1), $urandom_range(1, 3));
                fetch(EXC_VEC, $urandom_range(0, 2), $urandom_range(1, 3), $urandom);
            end else begin
                fetch(npc, $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
